// File: rtl/decompressor_feeder_if.sv
// rtl/decompressor_feeder_if.sv - compressed byte stream in, item stream out to the decompressor
interface decompressor_feeder_if;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [15:0] data_in;
  logic        control_word_in;
  logic        data_in_valid;
  logic        decompressor_busy;

  // master is the feeder itself; slave is whatever surrounds it
  modport master (
    input  in_byte, in_valid, in_last, decompressor_busy,
    output in_ready, data_in, control_word_in, data_in_valid
  );
  modport slave (
    output in_byte, in_valid, in_last, decompressor_busy,
    input  in_ready, data_in, control_word_in, data_in_valid
  );
endinterface

// File: rtl/decompressor_feeder.sv
// rtl/decompressor_feeder.sv - splits an LZRW1 byte stream into control bits and items
module decompressor_feeder #(
  parameter int COUNT_WIDTH = 16,
  parameter int BUSY_GUARD  = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clear,
  decompressor_feeder_if.master    bus,
  output logic                     done,
  output logic                     error,
  output logic [COUNT_WIDTH-1:0]   item_count
);

  typedef enum logic [2:0] {
    ST_CTRL, ST_HI, ST_LO, ST_ISSUE, ST_GUARD, ST_DONE, ST_ERR
  } state_e;

  localparam logic [2:0] GUARD_LAST = 3'(BUSY_GUARD - 1);

  state_e                 state_q, state_d;
  logic [7:0]             ctrl_q, ctrl_d;
  logic [2:0]             idx_q, idx_d;
  logic [15:0]            data_q, data_d;
  logic                   cw_q, cw_d;
  logic                   last_q, last_d;
  logic                   valid_q, valid_d;
  logic                   run_q, run_d;
  logic [2:0]             guard_q, guard_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   accept;
  logic                   xfer;
  logic                   cur_bit;

  assign cur_bit = ctrl_q[3'd7 - idx_q];

  // run_q keeps in_ready low until the first edge after reset is released
  assign bus.in_ready = run_q &&
                        (state_q == ST_CTRL || state_q == ST_HI || state_q == ST_LO);
  assign accept = bus.in_valid && bus.in_ready && !clear;
  assign xfer   = valid_q && !bus.decompressor_busy;

  assign bus.data_in         = data_q;
  assign bus.control_word_in = cw_q;
  assign bus.data_in_valid   = valid_q;
  assign done                = (state_q == ST_DONE);
  assign error               = (state_q == ST_ERR);
  assign item_count          = count_q;

  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    idx_d   = idx_q;
    data_d  = data_q;
    cw_d    = cw_q;
    last_d  = last_q;
    guard_d = guard_q;
    count_d = count_q;
    valid_d = 1'b0;
    run_d   = 1'b1;

    case (state_q)
      ST_CTRL: begin
        if (accept) begin
          ctrl_d  = bus.in_byte;
          idx_d   = 3'd0;
          last_d  = 1'b0;
          state_d = bus.in_last ? ST_DONE : ST_HI;
        end
      end
      ST_HI: begin
        if (accept) begin
          cw_d = cur_bit;
          if (cur_bit) begin
            data_d[15:8] = bus.in_byte;
            state_d      = bus.in_last ? ST_ERR : ST_LO;
          end else begin
            data_d  = {8'h00, bus.in_byte};
            last_d  = bus.in_last;
            state_d = ST_ISSUE;
          end
        end
      end
      ST_LO: begin
        if (accept) begin
          data_d[7:0] = bus.in_byte;
          last_d      = bus.in_last;
          state_d     = ST_ISSUE;
        end
      end
      // First ISSUE cycle only raises valid; the handshake is judged from the next one
      ST_ISSUE: begin
        if (xfer) begin
          count_d = count_q + COUNT_WIDTH'(1);
          idx_d   = idx_q + 3'd1;
          guard_d = 3'd0;
          state_d = ST_GUARD;
        end else begin
          valid_d = 1'b1;
        end
      end
      ST_GUARD: begin
        if (guard_q == GUARD_LAST) begin
          if (last_q)              state_d = ST_DONE;
          else if (idx_q == 3'd0)  state_d = ST_CTRL;
          else                     state_d = ST_HI;
        end else begin
          guard_d = guard_q + 3'd1;
        end
      end
      ST_DONE: state_d = ST_CTRL;
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_CTRL;
    endcase

    if (clear) begin
      state_d = ST_CTRL;
      idx_d   = 3'd0;
      last_d  = 1'b0;
      count_d = '0;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_CTRL;
      ctrl_q  <= 8'h00;
      idx_q   <= 3'd0;
      data_q  <= 16'h0000;
      cw_q    <= 1'b0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      run_q   <= 1'b0;
      guard_q <= 3'd0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      cw_q    <= cw_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      run_q   <= run_d;
      guard_q <= guard_d;
      count_q <= count_d;
    end
  end

endmodule

// File: doc/decompressor_feeder.md
# decompressor_feeder

Front-end sequencer for `decompressor_top`. It accepts the raw LZRW1 compressed byte stream over a valid/ready handshake and splits it into control bytes and items. Each item is packed into a 16-bit `data_in` word and paired with its control bit. Items are issued to the decompressor one at a time, honouring `decompressor_busy`, and the block reports end of stream and malformed streams.

## Interface
- `COUNT_WIDTH`, 16, width of the issued-item counter.
- `BUSY_GUARD`, 1, cycles (1..7) that `data_in_valid` stays low after each transfer before `decompressor_busy` is trusted again.

- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low.
- `clear`  in  1  synchronous flush: return to CTRL, clear `error` and `item_count`.
- `in_byte`  in  8  compressed stream byte.
- `in_valid`  in  1  `in_byte` valid.
- `in_last`  in  1  qualifies the final byte of the stream.
- `in_ready`  out  1  feeder accepts `in_byte` this cycle.
- `data_in`  out  16  item word to the decompressor.
- `control_word_in`  out  1  control bit for `data_in` (1 = copy, 0 = literal).
- `data_in_valid`  out  1  item offered to the decompressor.
- `decompressor_busy`  in  1  decompressor cannot accept.
- `done`  out  1  one-cycle pulse after the last item is transferred.
- `error`  out  1  sticky malformed-stream flag.
- `item_count`  out  COUNT_WIDTH  items transferred since reset/clear; wraps modulo 2^COUNT_WIDTH.

## Operation
- Stream format: one control byte, then up to 8 items.
  - Control bits are consumed MSB first: bit 7 governs item 0.
  - Literal item (bit 0) is 1 byte. `data_in = {8'h00, byte}`.
  - Copy item (bit 1) is 2 bytes. First byte goes to `data_in[15:8]`, second to `data_in[7:0]`.
- State machine:
  - CTRL: `in_ready=1`. Byte accepted → latch control byte, `idx=0`. With `in_last` → DONE (empty group, no items); otherwise → HI.
  - HI: `in_ready=1`. Byte accepted, current bit 0 → latch low byte → ISSUE. Current bit 1 → latch high byte → LO; with `in_last` → ERR.
  - LO: `in_ready=1`. Byte accepted → latch low byte → ISSUE. Record `in_last`.
  - ISSUE: `data_in_valid=1`, with `data_in`/`control_word_in` stable.
    - Transfer occurs on the rising edge where `decompressor_busy=0`. At that edge `item_count++` and `idx++` (3-bit, wraps 7→0).
    - Then → GUARD.
  - GUARD: `data_in_valid=0` for BUSY_GUARD cycles, then:
    - → DONE if the recorded last flag is set;
    - else → CTRL if `idx` wrapped to 0;
    - else → HI.
  - DONE: `done=1` for one cycle → CTRL.
  - ERR: `error=1`, `in_ready=0`. Leaves only on `clear` or `reset`.
- `in_last` on a literal item or copy second byte ends the stream after that item; remaining control bits are discarded.
- `clear` has priority over every state transition. Any partially assembled item is dropped; an item held in ISSUE is withdrawn (`data_in_valid` low next cycle).
- `in_ready` is a function of state only, never of `in_valid`.

## Timing
- Reset values:
  - `in_ready=0`, `data_in=16'h0000`, `control_word_in=0`, `data_in_valid=0`, `done=0`, `error=0`, `item_count=0`.
  - State CTRL, so `in_ready` is 1 from the first clock after deassertion.
- `reset` assertion mid-item abandons it immediately and asynchronously; outputs return to reset values.
- Literal byte accepted at edge N → `data_in_valid` high during cycle N+1. With busy low, the transfer completes at edge N+2.
- Copy: second byte accepted at edge N → `data_in_valid` in cycle N+1.
- Minimum item period (busy always low):
  - literal: 3 + BUSY_GUARD cycles;
  - copy: 4 + BUSY_GUARD cycles.
- `done` rises in the cycle after the final GUARD cycle.
- Simultaneous `in_valid` and `clear`: the byte is not consumed.

## Test plan
- Control `8'h00`, then literals `'a','b',...,'h'`, `in_last` on `'h'`, busy tied 0:
  - 8 transfers `16'h0061..16'h0068`, `control_word_in=0`;
  - `done` pulse; `item_count=8`; next byte treated as a control byte.
- Control `8'h40`, then bytes `41`, `{12,34}`, `42` (`in_last`):
  - transfers `0041`/0, `1234`/1, `0042`/0, then `done`.
- Busy held high for 5 cycles while in ISSUE:
  - `data_in_valid` held and `data_in` stable for all 5 cycles;
  - exactly one transfer on the first edge with busy low;
  - `item_count` increments by exactly 1.
- Control `8'h80`, copy first byte with `in_last`:
  - `error=1`, `in_ready=0`, no transfer;
  - `clear` pulse → `error=0`, `item_count=0`, `in_ready=1`.
- Two full groups (16 literals), `in_last` on 16th:
  - the 10th accepted byte is parsed as the second control byte;
  - `item_count=16`; one `done`.
- Async reset asserted while in ISSUE:
  - `data_in_valid` low immediately, with no clock edge required;
  - after release, `in_ready=1` and `item_count=0`.
